// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-strobe/pattern controls in, raster timing and pixel out.
// The master side is the timing generator; the slave side is the consumer
// (DAC driver or a test harness).
interface vga_timing_gen_if #(
    parameter int PIX_W   = 3,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FRAME_W = 8
);
    logic               pix_en;
    logic [1:0]         mode;
    logic [PIX_W-1:0]   solid_color;
    logic [PIX_W-1:0]   pixel_in;

    logic               hsync;
    logic               vsync;
    logic               de;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;
    logic [PIX_W-1:0]   pixel;

    modport master (
        input  pix_en, mode, solid_color, pixel_in,
        output hsync, vsync, de, x, y, line_start, frame_start, frame_cnt, pixel
    );

    modport slave (
        output pix_en, mode, solid_color, pixel_in,
        input  hsync, vsync, de, x, y, line_start, frame_start, frame_cnt, pixel
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with test patterns.
// h/v counters step on pix_en; every output is registered from the same slot
// on the same strobe, so sync/de/coords/pixel stay mutually aligned and the
// sync pins have no combinational path.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int PIX_W     = 3,
    parameter int BAR_SHIFT = 6,
    parameter int CHK_SHIFT = 5,
    parameter int FRAME_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = $clog2(H_TOTAL);
    localparam int Y_W      = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
    localparam logic           HS_ON  = (HS_POL != 0);
    localparam logic           VS_ON  = (VS_POL != 0);

    logic [X_W-1:0]     h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]     v_cnt_q, v_cnt_d;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic [1:0]         mode_q;
    logic               first_frame_q;

    logic [1:0]         mode_eff;
    logic               h_zero;
    logic               slot_zero;
    logic               chk_bit;
    int                 h_i;
    int                 v_i;

    // Next raster position: h wraps at H_TOTAL-1, v steps on h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Slot decode: sync windows, active area and the pattern pixel for (h, v).
    always_comb begin
        h_i           = int'(h_cnt_q);
        v_i           = int'(v_cnt_q);
        h_zero        = (h_cnt_q == '0);
        slot_zero     = h_zero && (v_cnt_q == '0);
        de_d          = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
        hsync_d       = ((h_i >= HS_START) && (h_i < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d       = ((v_i >= VS_START) && (v_i < VS_END)) ? VS_ON : ~VS_ON;
        line_start_d  = vif.pix_en && h_zero;
        frame_start_d = vif.pix_en && slot_zero;
        // The first slot of a frame already uses the freshly sampled mode.
        mode_eff      = slot_zero ? vif.mode : mode_q;
        chk_bit       = (((h_i >> CHK_SHIFT) ^ (v_i >> CHK_SHIFT)) & 1) != 0;
        pixel_d       = '0;
        case (mode_eff)
            2'd0:    pixel_d = PIX_W'(h_i >> BAR_SHIFT);
            2'd1:    pixel_d = {PIX_W{chk_bit}};
            2'd2:    pixel_d = vif.solid_color;
            default: pixel_d = vif.pixel_in;
        endcase
        if (!de_d) begin
            pixel_d = '0;
        end
    end

    // Raster counters advance one slot per pixel strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (vif.pix_en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Output stage: load the decoded current slot on a strobe, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pixel_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (vif.pix_en) begin
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                de_q    <= de_d;
                x_q     <= h_cnt_q;
                y_q     <= v_cnt_q;
                pixel_q <= pixel_d;
            end
        end
    end

    // Frame boundary: latch the pattern mode and count completed frames
    // (the very first frame after reset is not a completed one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= 2'd0;
            frame_cnt_q   <= '0;
            first_frame_q <= 1'b1;
        end else if (frame_start_d) begin
            mode_q        <= vif.mode;
            first_frame_q <= 1'b0;
            if (!first_frame_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_cnt   = frame_cnt_q;
    assign vif.pixel       = pixel_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two generators (small low-polarity geometry with a gated
// strobe, tiny high-polarity geometry with pix_en tied high) compared every
// clk against a slot-index reference model, plus directed boundary checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int X1 = $clog2(56);
    localparam int Y1 = $clog2(36);
    localparam int X2 = $clog2(14);
    localparam int Y2 = $clog2(7);

    typedef struct {
        int   ha, hfp, hs, hbp, va, vfp, vs, vbp;
        logic hpol, vpol;
        int   bar, chk, fw;
    } geom_t;

    typedef struct {
        logic       hs, vs, de, ls, fs;
        int         x, y, fc;
        logic [2:0] pix;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pen_v;
    logic [1:0] mode_v;
    logic [2:0] solid_v;
    logic [2:0] pin_v;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.PIX_W(3), .X_W(X1), .Y_W(Y1), .FRAME_W(8)) if1 ();
    vga_timing_gen_if #(.PIX_W(3), .X_W(X2), .Y_W(Y2), .FRAME_W(8)) if2 ();

    assign if1.pix_en      = pen_v;
    assign if1.mode        = mode_v;
    assign if1.solid_color = solid_v;
    assign if1.pixel_in    = pin_v;
    assign if2.pix_en      = 1'b1;
    assign if2.mode        = mode_v;
    assign if2.solid_color = solid_v;
    assign if2.pixel_in    = pin_v;

    vga_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .PIX_W(3), .BAR_SHIFT(3), .CHK_SHIFT(2), .FRAME_W(8)
    ) dut1 (.clk(clk), .rst_n(rst_n), .vif(if1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIX_W(3), .BAR_SHIFT(1), .CHK_SHIFT(1), .FRAME_W(8)
    ) dut2 (.clk(clk), .rst_n(rst_n), .vif(if2));

    geom_t      g1, g2;
    exp_t       e1, e2;
    longint     k1, k2;
    logic [1:0] ml1, ml2;
    logic       strobe1;
    int         checks, errors;
    longint     cyc;
    longint     last_ls2, last_fs2;
    int         nfs2;
    int         meas, m_strobes, m_lines, m_de, m_hs, m_vs_lines, m_hs_minx, m_vs_miny;

    function automatic exp_t ref_out(geom_t g, longint k, logic [1:0] m_in, logic [1:0] m_lat,
                                     logic [2:0] sc, logic [2:0] pin);
        exp_t   e;
        int     ht = g.ha + g.hfp + g.hs + g.hbp;
        int     vt = g.va + g.vfp + g.vs + g.vbp;
        longint f  = longint'(ht) * longint'(vt);
        longint s  = k % f;
        int     h  = int'(s % ht);
        int     v  = int'(s / ht);
        logic [1:0] m = (s == 0) ? m_in : m_lat;
        e.x   = h;
        e.y   = v;
        e.de  = (h < g.ha) && (v < g.va);
        e.hs  = (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs) ? g.hpol : ~g.hpol;
        e.vs  = (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs) ? g.vpol : ~g.vpol;
        e.ls  = (h == 0);
        e.fs  = (s == 0);
        e.fc  = int'((k / f) % (longint'(1) << g.fw));
        case (m)
            2'd0:    e.pix = 3'((h >> g.bar) % 8);
            2'd1:    e.pix = ((((h >> g.chk) ^ (v >> g.chk)) & 1) != 0) ? 3'd7 : 3'd0;
            2'd2:    e.pix = sc;
            default: e.pix = pin;
        endcase
        if (!e.de) e.pix = 3'd0;
        return e;
    endfunction

    function automatic exp_t reset_exp(geom_t g);
        exp_t e;
        e.hs = ~g.hpol; e.vs = ~g.vpol; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        e.x = 0; e.y = 0; e.fc = 0; e.pix = 3'd0;
        return e;
    endfunction

    function automatic longint frame_len(geom_t g);
        return longint'(g.ha + g.hfp + g.hs + g.hbp) * longint'(g.va + g.vfp + g.vs + g.vbp);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        k1 = 0; k2 = 0; ml1 = 2'd0; ml2 = 2'd0;
        e1 = reset_exp(g1); e2 = reset_exp(g2);
        last_ls2 = -1; last_fs2 = -1; nfs2 = 0;
        strobe1 = 1'b0;
    endtask

    task automatic model_edge();
        strobe1 = 1'b0;
        if (!rst_n) return;
        if (pen_v) begin
            e1 = ref_out(g1, k1, mode_v, ml1, solid_v, pin_v);
            if (k1 % frame_len(g1) == 0) ml1 = mode_v;
            k1++;
            strobe1 = 1'b1;
        end else begin
            e1.ls = 1'b0;
            e1.fs = 1'b0;
        end
        e2 = ref_out(g2, k2, mode_v, ml2, solid_v, pin_v);
        if (k2 % frame_len(g2) == 0) ml2 = mode_v;
        k2++;
    endtask

    task automatic check_all();
        chk("d1_x",   32'(if1.x),           32'(e1.x));
        chk("d1_y",   32'(if1.y),           32'(e1.y));
        chk("d1_de",  32'(if1.de),          32'(e1.de));
        chk("d1_hs",  32'(if1.hsync),       32'(e1.hs));
        chk("d1_vs",  32'(if1.vsync),       32'(e1.vs));
        chk("d1_ls",  32'(if1.line_start),  32'(e1.ls));
        chk("d1_fs",  32'(if1.frame_start), 32'(e1.fs));
        chk("d1_fc",  32'(if1.frame_cnt),   32'(e1.fc));
        chk("d1_pix", 32'(if1.pixel),       32'(e1.pix));
        chk("d2_x",   32'(if2.x),           32'(e2.x));
        chk("d2_y",   32'(if2.y),           32'(e2.y));
        chk("d2_de",  32'(if2.de),          32'(e2.de));
        chk("d2_hs",  32'(if2.hsync),       32'(e2.hs));
        chk("d2_vs",  32'(if2.vsync),       32'(e2.vs));
        chk("d2_ls",  32'(if2.line_start),  32'(e2.ls));
        chk("d2_fs",  32'(if2.frame_start), 32'(e2.fs));
        chk("d2_fc",  32'(if2.frame_cnt),   32'(e2.fc));
        chk("d2_pix", 32'(if2.pixel),       32'(e2.pix));
    endtask

    task automatic chk_reset_vals();
        chk("rst_d1_x",   32'(if1.x),           0);
        chk("rst_d1_y",   32'(if1.y),           0);
        chk("rst_d1_de",  32'(if1.de),          0);
        chk("rst_d1_hs",  32'(if1.hsync),       1);
        chk("rst_d1_vs",  32'(if1.vsync),       1);
        chk("rst_d1_ls",  32'(if1.line_start),  0);
        chk("rst_d1_fs",  32'(if1.frame_start), 0);
        chk("rst_d1_fc",  32'(if1.frame_cnt),   0);
        chk("rst_d1_pix", 32'(if1.pixel),       0);
        chk("rst_d2_hs",  32'(if2.hsync),       0);
        chk("rst_d2_vs",  32'(if2.vsync),       0);
        chk("rst_d2_x",   32'(if2.x),           0);
    endtask

    // One clk: model follows the edge, outputs are compared half a period later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
        if (rst_n) begin
            if (if2.line_start) begin
                if (last_ls2 >= 0) chk("d2_line_period", 32'(cyc - last_ls2), 14);
                last_ls2 = cyc;
            end
            if (if2.frame_start) begin
                if (last_fs2 >= 0) chk("d2_frame_period", 32'(cyc - last_fs2), 98);
                last_fs2 = cyc;
                nfs2++;
                if (nfs2 == 4) chk("d2_fc_after4", 32'(if2.frame_cnt), 3);
            end
        end
        if (strobe1) begin
            if (meas == 2 && if1.frame_start) meas = 3;
            else if (meas == 1 && if1.frame_start) meas = 2;
            if (meas == 2) begin
                m_strobes++;
                if (if1.line_start) m_lines++;
                if (if1.de) m_de++;
                if (if1.hsync == 1'b0) begin
                    m_hs++;
                    if (int'(if1.x) < m_hs_minx) m_hs_minx = int'(if1.x);
                end
                if (if1.vsync == 1'b0) begin
                    if (if1.line_start) m_vs_lines++;
                    if (int'(if1.y) < m_vs_miny) m_vs_miny = int'(if1.y);
                end
            end
        end
    endtask

    task automatic wait_xy(input int xw, input int yw, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 3 * 2016 && !found; i++) begin
            tick();
            if (int'(if1.x) == xw && int'(if1.y) == yw) found = 1'b1;
        end
        chk(tag, 32'(found), 1);
    endtask

    initial begin
        logic found;
        int   snap_x, snap_y, ls_n;
        checks = 0; errors = 0; cyc = 0; meas = 0;
        m_strobes = 0; m_lines = 0; m_de = 0; m_hs = 0; m_vs_lines = 0;
        m_hs_minx = 999; m_vs_miny = 999;
        g1 = '{40, 4, 6, 6, 30, 2, 2, 2, 1'b0, 1'b0, 3, 2, 8};
        g2 = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 1, 1, 8};
        rst_n = 1'b0; pen_v = 1'b0; mode_v = 2'd0; solid_v = 3'd0; pin_v = 3'd0;
        model_reset();

        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;

        // Full frame, strobe every 4th clk, colour bars: measure the raster.
        meas = 1;
        for (int i = 0; i < 2 * 8064 + 400 && meas != 3; i++) begin
            pen_v   = (i % 4 == 3);
            solid_v = 3'($urandom);
            pin_v   = 3'($urandom);
            tick();
        end
        chk("meas_done",    32'(meas),       3);
        chk("strobes",      32'(m_strobes),  2016);
        chk("lines",        32'(m_lines),    36);
        chk("de_strobes",   32'(m_de),       1200);
        chk("hs_strobes",   32'(m_hs),       216);
        chk("hs_first_x",   32'(m_hs_minx),  44);
        chk("vs_lines",     32'(m_vs_lines), 2);
        chk("vs_first_y",   32'(m_vs_miny),  32);

        // Mode switch mid-frame: takes effect only at the next frame start.
        pen_v = 1'b1;
        wait_xy(0, 10, "reach_line10");
        mode_v = 2'd1;
        found = 1'b0;
        for (int i = 0; i < 2 * 2016 && !found; i++) begin
            tick();
            if (if1.frame_start) found = 1'b1;
        end
        chk("mode_fs_seen", 32'(found), 1);
        chk("chk_pix_0_0",  32'(if1.pixel), 0);
        repeat (4) tick();
        chk("chk_x4",       32'(if1.x), 4);
        chk("chk_pix_4_0",  32'(if1.pixel), 7);
        mode_v = 2'd2;

        // Solid colour then passthrough, random strobes and pixel sources.
        for (int i = 0; i < 5000; i++) begin
            pen_v   = ($urandom_range(0, 2) != 0);
            solid_v = (i < 2500) ? 3'b101 : 3'($urandom);
            pin_v   = 3'($urandom);
            tick();
        end
        mode_v = 2'd3;
        for (int i = 0; i < 5000; i++) begin
            pen_v   = ($urandom_range(0, 2) != 0);
            solid_v = 3'($urandom);
            pin_v   = 3'($urandom);
            tick();
        end

        // Asynchronous reset mid-line.
        pen_v = 1'b1;
        wait_xy(20, 15, "reach_mid");
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        pen_v = 1'b1;
        tick();
        chk("rel_x",  32'(if1.x),           0);
        chk("rel_y",  32'(if1.y),           0);
        chk("rel_fs", 32'(if1.frame_start), 1);
        chk("rel_fc", 32'(if1.frame_cnt),   0);

        // Freeze pix_en for 50 clk mid-active.
        wait_xy(10, 5, "reach_freeze");
        snap_x = int'(if1.x);
        snap_y = int'(if1.y);
        pen_v  = 1'b0;
        ls_n   = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if1.line_start) ls_n++;
        end
        chk("frz_x",  32'(if1.x),  32'(snap_x));
        chk("frz_y",  32'(if1.y),  32'(snap_y));
        chk("frz_de", 32'(if1.de), 1);
        chk("frz_ls", 32'(ls_n),   0);
        pen_v = 1'b1;
        tick();
        chk("resume_x", 32'(if1.x), 32'(snap_x + 1));

        for (int i = 0; i < 3000; i++) begin
            pen_v   = ($urandom_range(0, 1) != 0);
            mode_v  = 2'($urandom);
            solid_v = 3'($urandom);
            pin_v   = 3'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with built-in test-pattern source; successor to our fixed 640x480 sync generator.
- Fully configurable H/V geometry and sync polarity; advances only on a pixel-enable strobe, so the whole design stays in the single system clock domain.
- Provides mutually aligned sync, data-enable, coordinates, line/frame pulses, a frame counter and a mode-selectable pixel output that drives the DAC pins directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
PIX_W, 3, pixel output width
BAR_SHIFT, 6, colour-bar width = 2^BAR_SHIFT pixels
CHK_SHIFT, 5, checker square size = 2^CHK_SHIFT pixels
FRAME_W, 8, frame counter width
Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; X_W = clog2(H_TOTAL); Y_W = clog2(V_TOTAL).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel strobe, one clk wide; counters and outputs advance only when high
mode  in  2  0 colour bars, 1 checker, 2 solid, 3 external passthrough
solid_color  in  PIX_W  colour used in mode 2
pixel_in  in  PIX_W  external pixel used in mode 3
hsync  out  1  horizontal sync at HS_POL level when active
vsync  out  1  vertical sync at VS_POL level when active
de  out  1  data enable, high in the active area
x  out  X_W  horizontal position of the current output slot
y  out  Y_W  vertical position of the current output slot
line_start  out  1  one-clk pulse when the outputs move to x=0
frame_start  out  1  one-clk pulse when the outputs move to x=0, y=0
frame_cnt  out  FRAME_W  completed frames, wraps
pixel  out  PIX_W  pixel value, zero outside the active area

Behaviour:
- Interface: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values: internal h_cnt = v_cnt = 0, de = 0, x = y = 0, pixel = 0, frame_cnt = 0, line_start = frame_start = 0, latched mode = 0.
  - hsync resets to ~HS_POL; vsync resets to ~VS_POL.
  - Reset asserted mid-line/mid-frame takes effect immediately (async); the raster restarts from (0,0).
- Counters, on clk when pix_en = 1:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt = H_TOTAL-1 and wraps to 0 after V_TOTAL-1.
  - Exactly H_TOTAL x V_TOTAL slots per frame; no extra slot at wrap.
- Output stage:
  - All outputs are registered and load from the current (h_cnt, v_cnt) on the same pix_en clk; latency is one pix_en period from the counters.
  - All outputs always describe the same slot (x = slot h, y = slot v).
  - Outputs hold between strobes.
- Decode for slot (h, v):
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; exactly H_SYNC slots.
  - vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines; exactly V_SYNC lines.
  - line_start = pix_en && h == 0. frame_start = pix_en && h == 0 && v == 0. Both pulse one clk only.
- frame_cnt increments on every frame_start except the first after reset, and wraps at 2^FRAME_W.
- Mode latching:
  - mode is sampled at the slot (0,0) load; that slot already uses the new mode.
  - Changes mid-frame are ignored until the next frame boundary, so there is no tearing.
- Pixel when de = 1, else 0:
  - mode 0: low PIX_W bits of (h >> BAR_SHIFT).
  - mode 1: all bits = h[CHK_SHIFT] ^ v[CHK_SHIFT].
  - mode 2: solid_color, sampled per slot.
  - mode 3: pixel_in, sampled on the loading clk.
- pix_en held low: everything frozen; no pulses.
- pix_en high continuously: the block runs at clk rate.
- Sync outputs must be glitch-free: register outputs, with no combinational path to the pins.

Test Plan:
- Defaults, pix_en every 4th clk, mode 0; count one frame -> exactly 800 strobes per line and 525 lines; hsync low for 96 strobes starting at x=656; vsync low for lines 490-491; de high 640x480 = 307200 strobes.
- Small geometry (H 8/2/2/2, V 4/1/1/1, HS_POL = VS_POL = 1), pix_en tied high -> period 14 clk, hsync high at x=10..11, frame = 98 clk; frame_start every 98 clk; frame_cnt = 3 after 4 frame_starts.
- Mode switch 0 -> 1 asserted at line 100 -> pattern unchanged until the next frame_start, then checker; pixel at (32,0) = 3'b111 and (0,0) = 3'b000.
- Mode 2 with solid_color = 3'b101; mode 3 driving pixel_in = x[2:0] -> pixel equals 3'b101 in the active area and 0 in blanking; passthrough matches the same-slot value.
- rst_n pulsed low mid-line at x=300, y=200 -> outputs go to reset values immediately without a clk edge; the first pix_en after release gives x=0, y=0, frame_start=1, frame_cnt=0.
- pix_en held low 50 clk mid-active -> x, y, de, sync and pixel are constant and no line_start occurs; on resume, x continues at +1.
